m2s_mem_responder: RTL and testbench
====================================

M2S_MEM_RESPONDER -- requirements
Module: m2s_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request queue entries (power of two, 2..16).
REQ-002 SHALL have parameter LAT, default 8, per-request service latency in cycles (1..255).
REQ-003 SHALL have port clk input 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n input 1, reset: asynchronous, active-low.
REQ-005 SHALL have port req_valid input 1, initiator presents an access.
REQ-006 SHALL have port req_ready output 1, responder can accept; equals queue not full.
REQ-007 SHALL have port req_type input 2, access kind; 1=load, 2=store, 0 and 3 invalid.
REQ-008 SHALL have port req_mod input 2, target module id.
REQ-009 SHALL have port req_addr input 8, access address.
REQ-010 SHALL have port rsp_valid output 1, completion present.
REQ-011 SHALL have port rsp_ready input 1, initiator consumes completion.
REQ-012 SHALL have ports rsp_type output 2, rsp_mod output 2 and rsp_addr output 8, echoes of the completed request.
REQ-013 SHALL have port rsp_tag output 4, sequence tag assigned at acceptance.
REQ-014 SHALL have port rsp_err output 1, completed request had invalid req_type.
REQ-015 SHALL have port outstanding output log2(DEPTH)+1, current queue occupancy.
REQ-016 SHALL have port step output 32, cycle count since reset release.

Function
REQ-017 Request accepted on any rising edge with req_valid && req_ready; fields and current tag written at queue tail.
REQ-018 Tag counter: 4-bit, increments per accepted request, wraps 15->0.
REQ-019 req_ready combinational = (outstanding != DEPTH); no push when full, even if a pop occurs the same cycle.
REQ-020 Responses strictly in acceptance order; queue read only at head.
REQ-021 FSM states IDLE, WAIT, RESP.
REQ-022 IDLE: if queue nonempty -> WAIT, cnt <= LAT-1; else stay.
REQ-023 WAIT: cnt != 0 -> cnt decrements; cnt == 0 -> RESP.
REQ-024 RESP: rsp_valid=1, rsp_* driven from head entry; held stable until rsp_valid && rsp_ready.
REQ-025 RESP handshake pops head -> IDLE.
REQ-026 Latency: empty queue in IDLE, accept at edge E -> rsp_valid high after edge E+LAT+1.
REQ-027 Back-to-back service: one response per LAT+2 cycles with rsp_ready tied 1.
REQ-028 rsp_valid=0 and rsp_* fields 0 outside RESP.
REQ-029 rsp_err=1 iff head req_type is 0 or 3; such entries still take full latency and handshake.
REQ-030 Push and pop on the same edge: outstanding unchanged, both take effect.
REQ-031 outstanding counts accepted, not-yet-popped entries, 0..DEPTH.
REQ-032 step increments every cycle after reset release, wraps 2^32-1 -> 0.
REQ-033 Pointers wrap modulo DEPTH, with no loss or duplication at wrap.

Reset
REQ-034 rst_n low asynchronously clears state to IDLE, cnt, queue pointers, outstanding, tag counter and step, and sets rsp_valid and rsp_* to 0.
REQ-035 While rst_n low, req_ready=1 (queue empty); no request accepted until the first edge after release.
REQ-036 Reset mid-WAIT or mid-RESP discards all queued entries; no completion emitted after release without new requests.

Verification
REQ-037 Single load: reset, accept type=1 mod=1 addr=8'hAA at edge E, LAT=8 -> rsp_valid after E+9, rsp_tag=0, rsp_addr=8'hAA, rsp_err=0.
REQ-038 Fill: push 5 requests back-to-back with rsp_ready=0 -> 4 accepted, req_ready=0 on the 5th, outstanding=4; then release rsp_ready -> tags 0,1,2,3 in order.
REQ-039 Backpressure: hold rsp_ready=0 for 20 cycles in RESP -> rsp_* fields stable, outstanding unchanged; rsp_ready=1 -> pop, FSM to IDLE next edge.
REQ-040 Invalid type: req_type=3 addr=8'h10 -> completion with rsp_err=1, rsp_type=3, same latency as valid access.
REQ-041 Tag wrap: 17 sequential requests -> 17th completion has rsp_tag=0.
REQ-042 Mid-op reset: assert rst_n=0 during WAIT with 3 outstanding -> immediately outstanding=0, rsp_valid=0, step=0; after release, no rsp_valid for 20 idle cycles.

Source files
------------

// File: rtl/m2s_mem_responder.sv
// m2s_mem_responder: in-order memory responder; queues requests and completes each
// one after a fixed service latency, echoing its fields with a sequence tag.
module m2s_mem_responder #(
    parameter int DEPTH = 4,
    parameter int LAT   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_type,
    input  logic [1:0]              req_mod,
    input  logic [7:0]              req_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_type,
    output logic [1:0]              rsp_mod,
    output logic [7:0]              rsp_addr,
    output logic [3:0]              rsp_tag,
    output logic                    rsp_err,
    output logic [$clog2(DEPTH):0]  outstanding,
    output logic [31:0]             step
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [3:0] tag;
    logic [1:0] q_type [DEPTH];
    logic [1:0] q_mod  [DEPTH];
    logic [7:0] q_addr [DEPTH];
    logic [3:0] q_tag  [DEPTH];
    logic push, pop;
    assign req_ready = outstanding != FULL;
    assign push = req_valid && req_ready;
    assign pop = rsp_valid && rsp_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag         <= '0;
            outstanding <= '0;
            step        <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            wr_ptr      <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr      <= pop ? rd_ptr + 1'b1 : rd_ptr;
            tag         <= push ? tag + 4'd1 : tag;
            outstanding <= outstanding + (AW+1)'(push) - (AW+1)'(pop);
            step        <= step + 32'd1;
        end
    end
    // Payload storage needs no reset: entries are only visible via the head in RESP.
    always_ff @(posedge clk) begin
        if (push) begin
            q_type[wr_ptr] <= req_type;
            q_mod[wr_ptr]  <= req_mod;
            q_addr[wr_ptr] <= req_addr;
            q_tag[wr_ptr]  <= tag;
        end
    end
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (outstanding != '0) begin
                    state_nx = WAIT;
                    cnt_nx   = 8'(LAT - 1);
                end
            end
            WAIT: begin
                if (cnt != 8'd0) cnt_nx = cnt - 8'd1;
                else state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    assign rsp_type = rsp_valid ? q_type[rd_ptr] : '0;
    assign rsp_mod  = rsp_valid ? q_mod[rd_ptr]  : '0;
    assign rsp_addr = rsp_valid ? q_addr[rd_ptr] : '0;
    assign rsp_tag  = rsp_valid ? q_tag[rd_ptr]  : '0;
    assign rsp_err  = rsp_valid && (q_type[rd_ptr] == 2'd0 || q_type[rd_ptr] == 2'd3);
endmodule

// File: tb/tb_m2s_mem_responder.sv
// tb_m2s_mem_responder: directed vector table plus hand sequences for fill,
// backpressure, tag wrap and mid-operation reset.
module tb_m2s_mem_responder;
    localparam int DEPTH = 4;
    localparam int LAT   = 8;
    logic       clk, rst_n, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [1:0] req_type, req_mod, rsp_type, rsp_mod;
    logic [7:0] req_addr, rsp_addr;
    logic [3:0] rsp_tag;
    logic [2:0] outstanding;
    logic [31:0] step;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [1:0] t;
        logic [1:0] m;
        logic [7:0] a;
        logic [3:0] tag;
        logic       err;
    } vec_t;
    vec_t vecs [6];

    m2s_mem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_mod(req_mod), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type),
        .rsp_mod(rsp_mod), .rsp_addr(rsp_addr), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .outstanding(outstanding), .step(step)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rsp_valid && n < 100);
        if (!rsp_valid) chk("rsp_timeout", {31'd0, rsp_valid}, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("rst_outst", outstanding, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_step", step, 0);
        chk("rst_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
    endtask

    task automatic single(input logic [1:0] t, input logic [1:0] m, input logic [7:0] a,
                          input logic [3:0] tg, input logic e);
        int n;
        req_valid = 1; req_type = t; req_mod = m; req_addr = a;
        chk("issue_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 0;
        wait_rsp(n);
        chk("latency", n, LAT + 1);
        chk("rsp_type", rsp_type, t);
        chk("rsp_mod", rsp_mod, m);
        chk("rsp_addr", rsp_addr, a);
        chk("rsp_tag", rsp_tag, tg);
        chk("rsp_err", rsp_err, e);
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("pop_valid", rsp_valid, 0);
        chk("pop_addr", rsp_addr, 0);
        chk("pop_type", rsp_type, 0);
        chk("pop_outst", outstanding, 0);
    endtask

    initial begin
        int n;
        logic [7:0] held_addr;
        logic [3:0] held_tag;
        rst_n = 1; req_valid = 0; req_type = 0; req_mod = 0; req_addr = 0; rsp_ready = 0;
        vecs[0] = '{2'd1, 2'd1, 8'hAA, 4'd0, 1'b0};
        vecs[1] = '{2'd2, 2'd2, 8'h55, 4'd1, 1'b0};
        vecs[2] = '{2'd3, 2'd0, 8'h10, 4'd2, 1'b1};
        vecs[3] = '{2'd0, 2'd3, 8'hFF, 4'd3, 1'b1};
        vecs[4] = '{2'd1, 2'd0, 8'h00, 4'd4, 1'b0};
        vecs[5] = '{2'd2, 2'd3, 8'h80, 4'd5, 1'b0};
        do_reset();
        @(posedge clk); #1;
        chk("step_first", step, 1);
        chk("idle_valid", rsp_valid, 0);
        for (int i = 0; i < 6; i++) single(vecs[i].t, vecs[i].m, vecs[i].a, vecs[i].tag, vecs[i].err);

        // Fill: the fifth request must be refused while the queue is full.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1; req_type = 2'd1; req_mod = 2'(i); req_addr = 8'h20 + 8'(i);
            chk("fill_ready", req_ready, (i < 4) ? 1 : 0);
            @(posedge clk); #1;
        end
        req_valid = 0;
        chk("fill_outst", outstanding, 4);
        chk("fill_full", req_ready, 0);
        rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            wait_rsp(n);
            chk("drain_tag", rsp_tag, i);
            chk("drain_addr", rsp_addr, 8'h20 + 8'(i));
            if (i > 0) chk("drain_gap", n, LAT + 2);
        end
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("drain_valid", rsp_valid, 0);
        chk("drain_outst", outstanding, 0);

        // Backpressure: completion held stable for 20 cycles.
        req_valid = 1; req_type = 2'd2; req_mod = 2'd1; req_addr = 8'h77;
        @(posedge clk); #1;
        req_valid = 0;
        wait_rsp(n);
        chk("bp_latency", n, LAT + 1);
        chk("bp_tag", rsp_tag, 4);
        held_addr = rsp_addr;
        held_tag = rsp_tag;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_addr", rsp_addr, held_addr);
            chk("bp_tag_hold", rsp_tag, held_tag);
            chk("bp_outst", outstanding, 1);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("bp_pop_valid", rsp_valid, 0);
        chk("bp_pop_outst", outstanding, 0);

        // Tag wrap: the 17th request after reset carries tag 0 again.
        do_reset();
        for (int i = 0; i < 17; i++) single(2'd1, 2'd0, 8'(i), 4'(i), 1'b0);

        // Mid-operation reset while three requests are queued.
        do_reset();
        req_valid = 1; req_type = 2'd1;
        for (int i = 0; i < 3; i++) begin
            req_addr = 8'h40 + 8'(i);
            @(posedge clk); #1;
        end
        req_valid = 0;
        chk("mid_outst", outstanding, 3);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_outst", outstanding, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_step", step, 0);
        chk("mid_rst_ready", req_ready, 1);
        @(posedge clk); #2;
        rst_n = 1;
        @(posedge clk); #1;
        chk("mid_step1", step, 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("mid_no_rsp", rsp_valid, 0);
        end
        chk("mid_step21", step, 21);
        chk("mid_outst_end", outstanding, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
